acq_sequencer: RTL and testbench
================================

ACQ_SEQUENCER -- requirements
Module: acq_sequencer

Interface
REQ-001 SHALL have parameter CONV_LOW_CYCLES, default 4, width of adc_start_conv_n low pulse in clk_100 cycles (range 1..15).
REQ-002 SHALL have parameter CAPTURE_DELAY, default 40, clk_100 cycles from new_sample to sample_valid (range CONV_LOW_CYCLES+1..255).
REQ-003 SHALL use a single clock, clk_100; reset is synchronous and active-high.
REQ-004 clk_100  in  1  system clock, 100 MHz.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 acq_enable  in  1  software arm level; low forces IDLE.
REQ-007 trig_sel  in  1  0 = soft_trig, 1 = hw_trig.
REQ-008 soft_trig  in  1  software trigger, level-sampled.
REQ-009 hw_trig  in  1  external trigger, already synchronised to clk_100, rising edge used.
REQ-010 new_sample  in  1  one-cycle sample-rate strobe, 2 MHz.
REQ-011 n_samples  in  32  samples per shot; 0 = continuous; latched on ARMED entry.
REQ-012 fifo_full  in  1  stream FIFO full, backpressure.
REQ-013 adc_start_conv_n  out  1  ADC start conversion, active low.
REQ-014 sample_valid  out  1  one-cycle capture strobe to data producer.
REQ-015 sample_cnt  out  32  samples issued this shot.
REQ-016 acq_active  out  1  high in RUN.
REQ-017 acq_done  out  1  high in DONE.
REQ-018 overflow  out  1  sticky: sample_valid while fifo_full.
REQ-019 overrun  out  1  sticky: new_sample during busy conversion.
REQ-020 state  out  3  FSM state encoding for status register.

Function
REQ-021 FSM states SHALL be IDLE=0, ARMED=1, RUN=2, DONE=3.
REQ-022 IDLE->ARMED on acq_enable rising edge; n_samples latched, sample_cnt, overflow, overrun cleared on that cycle.
REQ-023 ARMED->RUN when selected trigger seen: soft_trig high, or hw_trig 0->1 edge.
REQ-024 In RUN, new_sample with no conversion busy SHALL start a conversion: adc_start_conv_n low starting next cycle for exactly CONV_LOW_CYCLES cycles.
REQ-025 sample_valid SHALL pulse exactly CAPTURE_DELAY cycles after the accepted new_sample; sample_cnt increments on the same cycle.
REQ-026 Conversion busy spans from accepted new_sample through the sample_valid cycle; new_sample in that window SHALL be ignored and set overrun.
REQ-027 sample_valid while fifo_full SHALL still pulse, still count, and set overflow.
REQ-028 RUN->DONE on the cycle after sample_cnt reaches latched n_samples (non-zero); never in continuous mode.
REQ-029 acq_enable low in any state SHALL go to IDLE next cycle, abort any conversion in progress, drive adc_start_conv_n high, suppress pending sample_valid.
REQ-030 DONE->IDLE only via acq_enable low; DONE SHALL ignore triggers and new_sample.
REQ-031 Trigger and new_sample on the same cycle as ARMED->RUN: that new_sample SHALL NOT be accepted.
REQ-032 sample_cnt SHALL saturate at 2^32-1 in continuous mode.
REQ-033 sample_cnt, overflow, overrun SHALL hold their values in DONE and IDLE until next arm.

Reset
REQ-034 On reset: state=IDLE, adc_start_conv_n=1, sample_valid=0, sample_cnt=0, acq_active=0, acq_done=0, overflow=0, overrun=0, internal counters and hw_trig edge register cleared.
REQ-035 Reset asserted mid-conversion SHALL take effect on the next edge with no further sample_valid.

Structure
REQ-036 State encoding and default CONV_LOW_CYCLES/CAPTURE_DELAY SHALL live in shared package acq_pkg.
REQ-037 Conversion timing (low pulse, delay counter, busy) SHALL be one sub-module, adc_conv_timer; FSM and counting stay in acq_sequencer.

Verification
REQ-038 Arm, soft_trig, n_samples=3, new_sample every 50 cycles -> three sample_valid each 40 cycles after strobe, 4-cycle conv_n lows, DONE with sample_cnt=3.
REQ-039 new_sample at t and t+20 -> second ignored, overrun=1, one sample_valid at t+40.
REQ-040 fifo_full held high during RUN -> sample_valid still pulses, overflow=1, sample_cnt advances.
REQ-041 acq_enable dropped 10 cycles after accepted new_sample -> IDLE next cycle, conv_n high, no sample_valid at +40.
REQ-042 trig_sel=1, hw_trig held high before arming -> stays ARMED until hw_trig goes 0 then 1.
REQ-043 reset asserted during conversion -> all outputs at reset values next cycle, no sample_valid.

Source files
------------

// File: rtl/acq_pkg.sv
// Shared definitions for the acquisition sequencer: FSM encoding and default timing.
package acq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        RUN   = 3'd2,
        DONE  = 3'd3
    } acq_state_t;

    localparam int CONV_LOW_CYCLES_DEF = 4;
    localparam int CAPTURE_DELAY_DEF   = 40;

endpackage

// File: rtl/acq_sequencer_if.sv
// Control/status bundle between the acquisition sequencer and its surroundings.
interface acq_sequencer_if;

    logic        acq_enable;
    logic        trig_sel;
    logic        soft_trig;
    logic        hw_trig;
    logic        new_sample;
    logic [31:0] n_samples;
    logic        fifo_full;
    logic        adc_start_conv_n;
    logic        sample_valid;
    logic [31:0] sample_cnt;
    logic        acq_active;
    logic        acq_done;
    logic        overflow;
    logic        overrun;
    logic [2:0]  state;

    modport slave (
        input  acq_enable, trig_sel, soft_trig, hw_trig, new_sample, n_samples, fifo_full,
        output adc_start_conv_n, sample_valid, sample_cnt, acq_active, acq_done,
               overflow, overrun, state
    );

    modport master (
        output acq_enable, trig_sel, soft_trig, hw_trig, new_sample, n_samples, fifo_full,
        input  adc_start_conv_n, sample_valid, sample_cnt, acq_active, acq_done,
               overflow, overrun, state
    );

endinterface

// File: rtl/adc_conv_timer.sv
// One ADC conversion: start_conv_n low pulse, capture delay counter and busy window.
module adc_conv_timer
    import acq_pkg::*;
#(
    parameter int CONV_LOW_CYCLES = CONV_LOW_CYCLES_DEF,
    parameter int CAPTURE_DELAY   = CAPTURE_DELAY_DEF
) (
    input  logic clk_100,
    input  logic reset,
    input  logic start,
    input  logic abort,
    output logic busy,
    output logic conv_n,
    output logic capture,
    output logic capture_next
);

    localparam logic [8:0] LOW_END   = 9'(CONV_LOW_CYCLES);
    localparam logic [8:0] DELAY_END = 9'(CAPTURE_DELAY);

    // elapsed counts edges since the accepted strobe; 9 bits so +1 never wraps
    logic [8:0] elapsed;
    logic [8:0] elapsed_inc;

    assign elapsed_inc  = elapsed + 9'd1;
    assign capture_next = busy && !abort && (elapsed_inc == DELAY_END);

    always_ff @(posedge clk_100) begin
        if (reset || abort) begin
            busy    <= 1'b0;
            elapsed <= '0;
            conv_n  <= 1'b1;
            capture <= 1'b0;
        end else if (start) begin
            busy    <= 1'b1;
            elapsed <= 9'd1;
            conv_n  <= 1'b0;
            capture <= 1'b0;
        end else if (busy) begin
            elapsed <= elapsed_inc;
            conv_n  <= (elapsed_inc > LOW_END);
            capture <= capture_next;
            // busy still covers the capture cycle itself
            busy    <= (elapsed != DELAY_END);
        end else begin
            conv_n  <= 1'b1;
            capture <= 1'b0;
        end
    end

endmodule

// File: rtl/acq_sequencer.sv
// Acquisition FSM: arming, trigger selection, per-shot sample counting and sticky errors.
module acq_sequencer
    import acq_pkg::*;
#(
    parameter int CONV_LOW_CYCLES = CONV_LOW_CYCLES_DEF,
    parameter int CAPTURE_DELAY   = CAPTURE_DELAY_DEF
) (
    input  logic            clk_100,
    input  logic            reset,
    acq_sequencer_if.slave  bus
);

    acq_state_t  state_q, state_d;
    logic        enable_q;
    logic        hw_trig_q;
    logic [31:0] n_latched;
    logic [31:0] cnt_q;
    logic        overflow_q;
    logic        overrun_q;
    logic        busy;
    logic        capture_next;
    logic        arm;
    logic        trig_seen;
    logic        accept;
    logic        strobe_busy;

    assign arm         = (state_q == IDLE) && bus.acq_enable && !enable_q;
    assign trig_seen   = bus.trig_sel ? (bus.hw_trig && !hw_trig_q) : bus.soft_trig;
    // state_q (not state_d) gates acceptance, so a strobe on the trigger cycle is dropped
    assign accept      = (state_q == RUN) && bus.acq_enable && bus.new_sample && !busy;
    assign strobe_busy = (state_q == RUN) && bus.acq_enable && bus.new_sample && busy;

    adc_conv_timer #(
        .CONV_LOW_CYCLES (CONV_LOW_CYCLES),
        .CAPTURE_DELAY   (CAPTURE_DELAY)
    ) u_timer (
        .clk_100      (clk_100),
        .reset        (reset),
        .start        (accept),
        .abort        (!bus.acq_enable),
        .busy         (busy),
        .conv_n       (bus.adc_start_conv_n),
        .capture      (bus.sample_valid),
        .capture_next (capture_next)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (arm) state_d = ARMED;
            ARMED:   if (trig_seen) state_d = RUN;
            RUN:     if ((n_latched != '0) && (cnt_q == n_latched)) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (!bus.acq_enable) state_d = IDLE;
    end

    always_ff @(posedge clk_100) begin
        if (reset) begin
            state_q    <= IDLE;
            enable_q   <= 1'b0;
            hw_trig_q  <= 1'b0;
            n_latched  <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            enable_q  <= bus.acq_enable;
            hw_trig_q <= bus.hw_trig;
            if (arm) begin
                n_latched  <= bus.n_samples;
                cnt_q      <= '0;
                overflow_q <= 1'b0;
                overrun_q  <= 1'b0;
            end else begin
                // count lands on the same edge that raises sample_valid
                if (capture_next && (cnt_q != '1)) cnt_q <= cnt_q + 32'd1;
                if (bus.sample_valid && bus.fifo_full) overflow_q <= 1'b1;
                if (strobe_busy) overrun_q <= 1'b1;
            end
        end
    end

    assign bus.state      = state_q;
    assign bus.sample_cnt = cnt_q;
    assign bus.acq_active = (state_q == RUN);
    assign bus.acq_done   = (state_q == DONE);
    assign bus.overflow   = overflow_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed, table-driven bench for acq_sequencer with default timing (4-cycle low, 40-cycle delay).
module tb_acq_sequencer;

    typedef struct packed {
        logic        en;
        logic        tsel;
        logic        st;
        logic        ht;
        logic        ns;
        logic        ff;
        logic [31:0] nsamp;
        logic [7:0]  edges;
        logic [2:0]  est;
        logic        econv;
        logic        esv;
        logic [31:0] ecnt;
        logic        eovf;
        logic        eovr;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    int   sv_seen;
    vec_t vecs[$];

    acq_sequencer_if bus();

    acq_sequencer dut (
        .clk_100 (clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_step(input int n);
        @(posedge clk);
        #1;
        bus.soft_trig  = 1'b0;
        bus.new_sample = 1'b0;
        if (n > 1) step(n - 1);
    endtask

    task automatic watch_sv(input int n);
        sv_seen = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (bus.sample_valid === 1'b1) sv_seen++;
        end
    endtask

    task automatic add(input logic en, input logic tsel, input logic st, input logic ht,
                       input logic ns, input logic ff, input logic [31:0] nsamp,
                       input int edges, input logic [2:0] est, input logic econv,
                       input logic esv, input logic [31:0] ecnt, input logic eovf,
                       input logic eovr);
        vec_t v;
        v.en = en; v.tsel = tsel; v.st = st; v.ht = ht; v.ns = ns; v.ff = ff;
        v.nsamp = nsamp; v.edges = 8'(edges); v.est = est; v.econv = econv;
        v.esv = esv; v.ecnt = ecnt; v.eovf = eovf; v.eovr = eovr;
        vecs.push_back(v);
    endtask

    task automatic check_all(input string tag, input logic [2:0] est, input logic econv,
                             input logic esv, input logic [31:0] ecnt, input logic eovf,
                             input logic eovr);
        chk({tag, ".state"}, 32'(bus.state), 32'(est));
        chk({tag, ".conv_n"}, 32'(bus.adc_start_conv_n), 32'(econv));
        chk({tag, ".sample_valid"}, 32'(bus.sample_valid), 32'(esv));
        chk({tag, ".sample_cnt"}, bus.sample_cnt, ecnt);
        chk({tag, ".overflow"}, 32'(bus.overflow), 32'(eovf));
        chk({tag, ".overrun"}, 32'(bus.overrun), 32'(eovr));
        chk({tag, ".acq_active"}, 32'(bus.acq_active), 32'(est == 3'd2));
        chk({tag, ".acq_done"}, 32'(bus.acq_done), 32'(est == 3'd3));
    endtask

    initial begin
        // en tsel st ht ns ff nsamp edges | state conv_n sv cnt ovf ovr
        // three-sample shot, strobes 50 cycles apart
        add(1, 0, 0, 0, 0, 0, 3,  1, 3'd1, 1, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 3,  1, 3'd2, 1, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1, 0, 3,  1, 3'd2, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 3,  3, 3'd2, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 3,  1, 3'd2, 1, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 3, 34, 3'd2, 1, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 3,  1, 3'd2, 1, 1, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0, 3,  1, 3'd2, 1, 0, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0, 3,  9, 3'd2, 1, 0, 1, 0, 0);
        add(1, 0, 0, 0, 1, 0, 3, 40, 3'd2, 1, 1, 2, 0, 0);
        add(1, 0, 0, 0, 0, 0, 3, 10, 3'd2, 1, 0, 2, 0, 0);
        add(1, 0, 0, 0, 1, 0, 3, 40, 3'd2, 1, 1, 3, 0, 0);
        add(1, 0, 0, 0, 0, 0, 3,  1, 3'd3, 1, 0, 3, 0, 0);
        add(1, 0, 1, 0, 1, 0, 3, 45, 3'd3, 1, 0, 3, 0, 0);
        add(0, 0, 0, 0, 0, 0, 3,  1, 3'd0, 1, 0, 3, 0, 0);
        // continuous mode, fifo_full held, strobe at t and t+20
        add(1, 0, 0, 0, 0, 0, 0,  1, 3'd1, 1, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 1, 0,  1, 3'd2, 1, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1, 1, 0, 20, 3'd2, 1, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1, 1, 0, 20, 3'd2, 1, 1, 1, 0, 1);
        add(1, 0, 0, 0, 0, 1, 0,  1, 3'd2, 1, 0, 1, 1, 1);
        add(1, 0, 0, 0, 0, 1, 0, 20, 3'd2, 1, 0, 1, 1, 1);
        // abort 10 cycles into a conversion
        add(1, 0, 0, 0, 1, 0, 0, 10, 3'd2, 1, 0, 1, 1, 1);
        add(0, 0, 0, 0, 0, 0, 0,  1, 3'd0, 1, 0, 1, 1, 1);
        add(0, 0, 0, 0, 0, 0, 0, 29, 3'd0, 1, 0, 1, 1, 1);
        // hw trigger held high before arming, strobe on the trigger cycle
        add(0, 1, 0, 1, 0, 0, 1,  2, 3'd0, 1, 0, 1, 1, 1);
        add(1, 1, 0, 1, 0, 0, 1,  1, 3'd1, 1, 0, 0, 0, 0);
        add(1, 1, 1, 1, 0, 0, 1,  5, 3'd1, 1, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 1,  2, 3'd1, 1, 0, 0, 0, 0);
        add(1, 1, 0, 1, 1, 0, 1,  1, 3'd2, 1, 0, 0, 0, 0);
        add(1, 1, 0, 1, 0, 0, 1, 40, 3'd2, 1, 0, 0, 0, 0);
        add(1, 1, 0, 1, 1, 0, 1, 40, 3'd2, 1, 1, 1, 0, 0);
        add(1, 1, 0, 1, 0, 0, 1,  1, 3'd3, 1, 0, 1, 0, 0);

        reset = 1'b1;
        bus.acq_enable = 1'b0; bus.trig_sel = 1'b0; bus.soft_trig = 1'b0;
        bus.hw_trig = 1'b0; bus.new_sample = 1'b0; bus.n_samples = '0; bus.fifo_full = 1'b0;
        step(3);
        check_all("reset", 3'd0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        reset = 1'b0;
        step(1);

        for (int i = 0; i < vecs.size(); i++) begin
            bus.acq_enable = vecs[i].en;
            bus.trig_sel   = vecs[i].tsel;
            bus.soft_trig  = vecs[i].st;
            bus.hw_trig    = vecs[i].ht;
            bus.new_sample = vecs[i].ns;
            bus.fifo_full  = vecs[i].ff;
            bus.n_samples  = vecs[i].nsamp;
            pulse_step(int'(vecs[i].edges));
            check_all($sformatf("v%0d", i), vecs[i].est, vecs[i].econv, vecs[i].esv,
                      vecs[i].ecnt, vecs[i].eovf, vecs[i].eovr);
        end

        // busy window ends after the capture cycle: strobe there is dropped, next one taken
        bus.acq_enable = 1'b0; bus.trig_sel = 1'b0; bus.hw_trig = 1'b0; bus.n_samples = 32'd0;
        step(1);
        bus.acq_enable = 1'b1;
        step(1);
        bus.soft_trig = 1'b1;
        pulse_step(1);
        bus.new_sample = 1'b1;
        pulse_step(40);
        check_all("edge.capture", 3'd2, 1'b1, 1'b1, 32'd1, 1'b0, 1'b0);
        bus.new_sample = 1'b1;
        pulse_step(1);
        check_all("edge.dropped", 3'd2, 1'b1, 1'b0, 32'd1, 1'b0, 1'b1);
        bus.new_sample = 1'b1;
        pulse_step(1);
        check_all("edge.taken", 3'd2, 1'b0, 1'b0, 32'd1, 1'b0, 1'b1);
        step(38);
        chk("edge.pre_capture2", 32'(bus.sample_valid), 32'd0);
        step(1);
        check_all("edge.capture2", 3'd2, 1'b1, 1'b1, 32'd2, 1'b0, 1'b1);

        // abort while the conversion pulse is still low
        bus.acq_enable = 1'b0;
        step(1);
        bus.acq_enable = 1'b1;
        step(1);
        bus.soft_trig = 1'b1;
        pulse_step(1);
        bus.new_sample = 1'b1;
        pulse_step(2);
        chk("abort.conv_low", 32'(bus.adc_start_conv_n), 32'd0);
        bus.acq_enable = 1'b0;
        step(1);
        check_all("abort.next", 3'd0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        watch_sv(45);
        chk("abort.no_capture", 32'(sv_seen), 32'd0);

        // reset in the middle of a conversion, with overrun already set
        bus.acq_enable = 1'b1;
        step(1);
        bus.soft_trig = 1'b1;
        pulse_step(1);
        bus.new_sample = 1'b1;
        pulse_step(1);
        bus.new_sample = 1'b1;
        pulse_step(1);
        check_all("rst.pre", 3'd2, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        reset = 1'b1;
        step(1);
        check_all("rst.mid", 3'd0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        reset = 1'b0;
        watch_sv(45);
        chk("rst.no_capture", 32'(sv_seen), 32'd0);
        chk("rst.cnt_after", bus.sample_cnt, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
